// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read-port register file with write-first bypass,
// per-register pending scoreboard and a bulk-clear sequencer.
module regfile_mp #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW = $clog2(NREGS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREAD*AW-1:0]     rd_addr,
  output logic [NREAD*XLEN-1:0]   rd_data,
  output logic [NREAD-1:0]        rd_pend,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [XLEN-1:0]         wr_data,
  input  logic                    iss_en,
  input  logic [AW-1:0]           iss_addr,
  input  logic                    clr_req,
  output logic                    busy
);
  typedef enum logic {IDLE, CLEARING} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [NREGS-1:0] pend_q, pend_d;
  logic [NREAD*XLEN-1:0] rd_data_q, rd_data_d;
  logic [NREAD-1:0] rd_pend_q, rd_pend_d;
  logic idle, we, ie;
  always_comb begin
    idle = state_q == IDLE;
    we = wr_en && idle && !(ZERO_REG && wr_addr == '0);
    ie = iss_en && idle && !(ZERO_REG && iss_addr == '0);
    regs_d = regs_q;
    pend_d = pend_q;
    state_d = state_q;
    cnt_d = cnt_q;
    rd_data_d = '0;
    rd_pend_d = '0;
    if (we) begin
      regs_d[wr_addr] = wr_data;
      pend_d[wr_addr] = 1'b0;
    end
    if (ie) pend_d[iss_addr] = 1'b1;
    // Issue/write on the clear-request edge land first, then the pend wipe overrides them
    if (idle && clr_req) begin
      pend_d = '0;
      cnt_d = '0;
      state_d = CLEARING;
    end
    if (!idle) begin
      regs_d[cnt_q] = '0;
      cnt_d = cnt_q + 1'b1;
      state_d = cnt_q == AW'(NREGS - 1) ? IDLE : CLEARING;
    end
    // Reads see post-edge state, giving write-first bypass
    for (int i = 0; i < NREAD; i++) begin
      rd_data_d[i*XLEN +: XLEN] = regs_d[rd_addr[i*AW +: AW]];
      rd_pend_d[i] = pend_d[rd_addr[i*AW +: AW]];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      pend_q <= '0;
      rd_data_q <= '0;
      rd_pend_q <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      rd_data_q <= rd_data_d;
      rd_pend_q <= rd_pend_d;
      regs_q <= regs_d;
    end
  end
  assign rd_data = rd_data_q;
  assign rd_pend = rd_pend_q;
  assign busy = state_q == CLEARING;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for a default regfile_mp and a 64-bit/16-reg/4-port, no-zero-reg variant.
module tb_regfile_mp;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic a_rst, a_wr_en, a_iss_en, a_clr_req, a_busy;
  logic [9:0] a_rd_addr;
  logic [63:0] a_rd_data;
  logic [1:0] a_rd_pend;
  logic [4:0] a_wr_addr, a_iss_addr;
  logic [31:0] a_wr_data;

  logic b_rst, b_wr_en, b_iss_en, b_clr_req, b_busy;
  logic [15:0] b_rd_addr;
  logic [255:0] b_rd_data;
  logic [3:0] b_rd_pend;
  logic [3:0] b_wr_addr, b_iss_addr;
  logic [63:0] b_wr_data;

  regfile_mp u_a (
    .clk(clk), .rst(a_rst), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_pend(a_rd_pend),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .iss_en(a_iss_en),
    .iss_addr(a_iss_addr), .clr_req(a_clr_req), .busy(a_busy)
  );
  regfile_mp #(.XLEN(64), .NREGS(16), .NREAD(4), .ZERO_REG(1'b0)) u_b (
    .clk(clk), .rst(b_rst), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_pend(b_rd_pend),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .iss_en(b_iss_en),
    .iss_addr(b_iss_addr), .clr_req(b_clr_req), .busy(b_busy)
  );

  typedef struct {
    logic [255:0] d;
    logic [3:0] p;
    logic b;
  } exp_t;
  exp_t qa[$], qb[$];
  int n_checks = 0, n_err = 0;

  logic [63:0] m_regs [2][32];
  logic m_pend [2][32];
  bit m_clr [2];
  int m_cnt [2];

  task automatic model_reset(input int k);
    for (int i = 0; i < 32; i++) begin
      m_regs[k][i] = '0;
      m_pend[k][i] = 1'b0;
    end
    m_clr[k] = 1'b0;
    m_cnt[k] = 0;
  endtask

  task automatic model_update(input int k, input logic we_i, input int wa, input logic [63:0] wd,
                              input logic ie_i, input int ia, input logic clr);
    int n = (k == 0) ? 32 : 16;
    bit z = (k == 0);
    bit idle = !m_clr[k];
    if (idle && we_i && !(z && wa == 0)) begin
      m_regs[k][wa] = wd;
      m_pend[k][wa] = 1'b0;
    end
    if (idle && ie_i && !(z && ia == 0)) m_pend[k][ia] = 1'b1;
    if (idle && clr) begin
      for (int i = 0; i < 32; i++) m_pend[k][i] = 1'b0;
      m_cnt[k] = 0;
      m_clr[k] = 1'b1;
    end else if (!idle) begin
      m_regs[k][m_cnt[k]] = '0;
      if (m_cnt[k] == n - 1) m_clr[k] = 1'b0;
      m_cnt[k]++;
    end
  endtask

  task automatic step;
    exp_t ea, eb;
    ea.d = '0; ea.p = '0;
    eb.d = '0; eb.p = '0;
    model_update(0, a_wr_en, int'(a_wr_addr), {32'd0, a_wr_data}, a_iss_en, int'(a_iss_addr), a_clr_req);
    model_update(1, b_wr_en, int'(b_wr_addr), b_wr_data, b_iss_en, int'(b_iss_addr), b_clr_req);
    for (int i = 0; i < 2; i++) begin
      ea.d[i*32 +: 32] = m_regs[0][a_rd_addr[i*5 +: 5]][31:0];
      ea.p[i] = m_pend[0][a_rd_addr[i*5 +: 5]];
    end
    ea.b = m_clr[0];
    for (int i = 0; i < 4; i++) begin
      eb.d[i*64 +: 64] = m_regs[1][b_rd_addr[i*4 +: 4]];
      eb.p[i] = m_pend[1][b_rd_addr[i*4 +: 4]];
    end
    eb.b = m_clr[1];
    qa.push_back(ea);
    qb.push_back(eb);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    exp_t ea, eb;
    a_rst = 1'b1; b_rst = 1'b1;
    #2;
    n_checks++;
    if ({a_rd_data, a_rd_pend, a_busy, b_rd_data, b_rd_pend, b_busy} !== '0) begin
      n_err++;
      $display("FAIL reset_init: got a=%h/%b/%b b=%h/%b/%b exp all zero", a_rd_data, a_rd_pend, a_busy, b_rd_data, b_rd_pend, b_busy);
    end
    #10;
    a_rst = 1'b0; b_rst = 1'b0;
    model_reset(0); model_reset(1);
    @(posedge clk); #1;
    a_wr_en = 1'b1; a_wr_addr = 5'd3; a_wr_data = 32'hAAAA5555; a_rd_addr = {5'd3, 5'd3};
    b_wr_en = 1'b1; b_wr_addr = 4'd2; b_wr_data = 64'h0123456789ABCDEF; b_rd_addr = {4'd2, 4'd2, 4'd2, 4'd2};
    b_iss_en = 1'b1; b_iss_addr = 4'd2;
    for (int s = 0; s < 5; s++) begin
      step();
      a_wr_en = 1'b0; b_wr_en = 1'b0; b_iss_en = 1'b0;
      a_clr_req = (s == 0);
      ea = qa.pop_front(); eb = qb.pop_front();
      n_checks += 2;
      if ({a_rd_data, a_rd_pend, a_busy} !== {ea.d[63:0], ea.p[1:0], ea.b}) begin
        n_err++;
        $display("FAIL reset_pre_a: got %h/%b/%b exp %h/%b/%b", a_rd_data, a_rd_pend, a_busy, ea.d[63:0], ea.p[1:0], ea.b);
      end
      if ({b_rd_data, b_rd_pend, b_busy} !== {eb.d, eb.p, eb.b}) begin
        n_err++;
        $display("FAIL reset_pre_b: got %h/%b/%b exp %h/%b/%b", b_rd_data, b_rd_pend, b_busy, eb.d, eb.p, eb.b);
      end
    end
    a_rst = 1'b1; b_rst = 1'b1;
    #2;
    n_checks++;
    if ({a_rd_data, a_rd_pend, a_busy, b_rd_data, b_rd_pend, b_busy} !== '0) begin
      n_err++;
      $display("FAIL reset_async: got a=%h/%b/%b b=%h/%b/%b exp all zero", a_rd_data, a_rd_pend, a_busy, b_rd_data, b_rd_pend, b_busy);
    end
    a_rst = 1'b0; b_rst = 1'b0;
    model_reset(0); model_reset(1);
    a_rd_addr = {5'd3, 5'd31};
    b_rd_addr = {4'd2, 4'd15, 4'd0, 4'd2};
    step();
    ea = qa.pop_front(); eb = qb.pop_front();
    n_checks += 2;
    if ({a_rd_data, a_rd_pend, a_busy} !== {ea.d[63:0], ea.p[1:0], ea.b} || a_rd_data !== '0) begin
      n_err++;
      $display("FAIL reset_read_a: got %h/%b/%b exp %h/%b/%b", a_rd_data, a_rd_pend, a_busy, ea.d[63:0], ea.p[1:0], ea.b);
    end
    if ({b_rd_data, b_rd_pend, b_busy} !== {eb.d, eb.p, eb.b} || b_rd_data !== '0) begin
      n_err++;
      $display("FAIL reset_read_b: got %h/%b/%b exp %h/%b/%b", b_rd_data, b_rd_pend, b_busy, eb.d, eb.p, eb.b);
    end
  endtask

  task automatic test_bypass;
    exp_t ea;
    a_wr_en = 1'b1; a_wr_addr = 5'd5; a_wr_data = 32'hDEADBEEF; a_rd_addr = {5'd0, 5'd5};
    for (int s = 0; s < 2; s++) begin
      step();
      a_wr_en = 1'b0; a_rd_addr = {5'd5, 5'd0};
      ea = qa.pop_front(); void'(qb.pop_front());
      n_checks++;
      if ({a_rd_data, a_rd_pend, a_busy} !== {ea.d[63:0], ea.p[1:0], ea.b} || a_rd_data[s*32 +: 32] !== 32'hDEADBEEF) begin
        n_err++;
        $display("FAIL bypass: cycle %0d got %h/%b exp %h/%b", s, a_rd_data, a_rd_pend, ea.d[63:0], ea.p[1:0]);
      end
    end
  endtask

  task automatic test_zero_reg;
    exp_t ea, eb;
    a_wr_en = 1'b1; a_wr_addr = 5'd0; a_wr_data = 32'h12345678; a_iss_en = 1'b1; a_iss_addr = 5'd0;
    a_rd_addr = {5'd0, 5'd0};
    b_wr_en = 1'b1; b_wr_addr = 4'd0; b_wr_data = 64'h12345678; b_rd_addr = {4'd1, 4'd0, 4'd0, 4'd0};
    for (int s = 0; s < 2; s++) begin
      step();
      a_wr_en = 1'b0; a_iss_en = 1'b0; b_wr_en = 1'b0;
      ea = qa.pop_front(); eb = qb.pop_front();
      n_checks += 2;
      if ({a_rd_data, a_rd_pend} !== {ea.d[63:0], ea.p[1:0]} || {a_rd_data, a_rd_pend} !== '0) begin
        n_err++;
        $display("FAIL zero_reg_a: cycle %0d got %h/%b exp %h/%b", s, a_rd_data, a_rd_pend, ea.d[63:0], ea.p[1:0]);
      end
      if ({b_rd_data, b_rd_pend} !== {eb.d, eb.p} || b_rd_data[63:0] !== 64'h12345678) begin
        n_err++;
        $display("FAIL zero_reg_b: cycle %0d got %h/%b exp %h/%b", s, b_rd_data, b_rd_pend, eb.d, eb.p);
      end
    end
  endtask

  task automatic test_scoreboard;
    exp_t ea;
    logic [1:0] want [3] = '{2'b11, 2'b00, 2'b11};
    a_rd_addr = {5'd7, 5'd7};
    for (int s = 0; s < 3; s++) begin
      a_iss_en = (s != 1); a_iss_addr = 5'd7;
      a_wr_en = (s != 0); a_wr_addr = 5'd7; a_wr_data = (s == 1) ? 32'h00000077 : 32'h1234ABCD;
      step();
      ea = qa.pop_front(); void'(qb.pop_front());
      n_checks++;
      if ({a_rd_data, a_rd_pend} !== {ea.d[63:0], ea.p[1:0]} || a_rd_pend !== want[s]) begin
        n_err++;
        $display("FAIL scoreboard: step %0d got %h/%b exp %h/%b", s, a_rd_data, a_rd_pend, ea.d[63:0], ea.p[1:0]);
      end
    end
    a_iss_en = 1'b0; a_wr_en = 1'b0;
  endtask

  task automatic test_clear;
    exp_t ea;
    int busy_cnt = 0;
    bit done = 1'b0;
    for (int i = 0; i < 32; i++) begin
      a_wr_en = 1'b1; a_wr_addr = 5'(i); a_wr_data = 32'(i); a_rd_addr = {5'(i), 5'd31};
      step();
      ea = qa.pop_front(); void'(qb.pop_front());
      n_checks++;
      if ({a_rd_data, a_rd_pend, a_busy} !== {ea.d[63:0], ea.p[1:0], ea.b}) begin
        n_err++;
        $display("FAIL clear_fill: r%0d got %h/%b exp %h/%b", i, a_rd_data, a_rd_pend, ea.d[63:0], ea.p[1:0]);
      end
    end
    a_wr_en = 1'b0; a_clr_req = 1'b1; a_iss_en = 1'b1; a_iss_addr = 5'd4; a_rd_addr = {5'd4, 5'd31};
    for (int s = 0; s < 40 && !done; s++) begin
      step();
      a_clr_req = 1'b0; a_iss_en = 1'b0;
      a_wr_en = 1'b1; a_wr_addr = 5'd9; a_wr_data = 32'hFFFFFFFF;
      a_rd_addr = {5'($urandom_range(0, 31)), 5'd31};
      ea = qa.pop_front(); void'(qb.pop_front());
      n_checks++;
      if ({a_rd_data, a_rd_pend, a_busy} !== {ea.d[63:0], ea.p[1:0], ea.b}) begin
        n_err++;
        $display("FAIL clear_run: cycle %0d got %h/%b/%b exp %h/%b/%b", s, a_rd_data, a_rd_pend, a_busy, ea.d[63:0], ea.p[1:0], ea.b);
      end
      if (a_busy) busy_cnt++;
      else done = 1'b1;
    end
    a_wr_en = 1'b0;
    n_checks++;
    if (!done || busy_cnt != 32) begin
      n_err++;
      $display("FAIL clear_busy_len: got %0d cycles (ended=%0b) exp 32", busy_cnt, done);
    end
    for (int i = 0; i < 32; i += 2) begin
      a_rd_addr = {5'(i + 1), 5'(i)};
      step();
      ea = qa.pop_front(); void'(qb.pop_front());
      n_checks++;
      if ({a_rd_data, a_rd_pend, a_busy} !== {ea.d[63:0], ea.p[1:0], ea.b} || a_rd_data !== '0) begin
        n_err++;
        $display("FAIL clear_after: r%0d got %h/%b exp %h/%b", i, a_rd_data, a_rd_pend, ea.d[63:0], ea.p[1:0]);
      end
    end
  endtask

  task automatic test_random;
    exp_t eb;
    int base;
    for (int c = 0; c < 1000; c++) begin
      b_wr_en = 1'($urandom); b_wr_addr = 4'($urandom); b_wr_data = {$urandom, $urandom};
      b_iss_en = 1'($urandom); b_iss_addr = 4'($urandom);
      b_clr_req = ($urandom_range(0, 63) == 0);
      base = $urandom_range(0, 15);
      for (int i = 0; i < 4; i++) b_rd_addr[i*4 +: 4] = 4'(base + i * 5);
      step();
      eb = qb.pop_front(); void'(qa.pop_front());
      n_checks++;
      if ({b_rd_data, b_rd_pend, b_busy} !== {eb.d, eb.p, eb.b}) begin
        n_err++;
        $display("FAIL random: cycle %0d got %h/%b/%b exp %h/%b/%b", c, b_rd_data, b_rd_pend, b_busy, eb.d, eb.p, eb.b);
      end
      if ($urandom_range(0, 99) == 0) begin
        b_rst = 1'b1;
        #2;
        n_checks++;
        if ({b_rd_data, b_rd_pend, b_busy} !== '0) begin
          n_err++;
          $display("FAIL random_rst: cycle %0d got %h/%b/%b exp zero", c, b_rd_data, b_rd_pend, b_busy);
        end
        b_rst = 1'b0;
        model_reset(1);
      end
    end
    b_wr_en = 1'b0; b_iss_en = 1'b0; b_clr_req = 1'b0;
  endtask

  initial begin
    a_wr_en = 1'b0; a_iss_en = 1'b0; a_clr_req = 1'b0; a_rd_addr = '0;
    a_wr_addr = '0; a_wr_data = '0; a_iss_addr = '0;
    b_wr_en = 1'b0; b_iss_en = 1'b0; b_clr_req = 1'b0; b_rd_addr = '0;
    b_wr_addr = '0; b_wr_data = '0; b_iss_addr = '0;
    test_reset();
    test_bypass();
    test_zero_reg();
    test_scoreboard();
    test_clear();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
